// File: rtl/dc_pkg.sv
// Shared widths and EOF sideband encoding for the 8<->32 width converters.
package dc_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned DC_BYTE_W      = 8;
    localparam int unsigned DC_WORD_W      = 32;
    localparam int unsigned DC_EOF_SB_W    = 3;
    localparam int unsigned DC_IDX_W       = 2;
    localparam int unsigned DC_ASM_W       = DC_WORD_W - DC_BYTE_W;

    localparam logic [DC_EOF_SB_W-1:0] EOF_FULL = 3'd4;

    // Valid-byte count of a final word whose last byte sits at idx.
    function automatic logic [DC_EOF_SB_W-1:0] eof_code(input logic [DC_IDX_W-1:0] idx);
        if (idx == 2'd3) begin
            return EOF_FULL;
        end
        return DC_EOF_SB_W'(idx) + 3'd1;
    endfunction

endpackage

// File: rtl/dc_8to32.sv
// Packs an 8-bit byte stream with SOF/EOF sideband into little-endian
// 32-bit words through a one-entry output holding register.
module dc_8to32
    import dc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_vld_i,
    input  logic [DC_BYTE_W-1:0]   s_data_i,
    input  logic                   s_sof,
    input  logic [DC_EOF_SB_W-1:0] s_eof_sb,
    output logic                   s_rdy_o,
    output logic                   m_vld_o,
    output logic [DC_WORD_W-1:0]   m_data_o,
    output logic                   m_sof,
    output logic [DC_EOF_SB_W-1:0] m_eof_sb,
    input  logic                   m_rdy_i,
    output logic                   sof_err
);

    logic [DC_ASM_W-1:0]    asm_data_q, asm_data_d;
    logic [DC_IDX_W-1:0]    idx_q, idx_d;
    logic                   asm_sof_q, asm_sof_d;
    logic                   m_vld_q, m_vld_d;
    logic [DC_WORD_W-1:0]   m_data_q, m_data_d;
    logic                   m_sof_q, m_sof_d;
    logic [DC_EOF_SB_W-1:0] m_eof_sb_q, m_eof_sb_d;
    logic                   sof_err_q, sof_err_d;

    logic                   accept_c;
    logic                   is_eof_c;
    logic                   complete_c;
    logic [DC_IDX_W-1:0]    eff_idx_c;
    logic                   eff_sof_c;
    logic [DC_WORD_W-1:0]   eff_data_c;
    logic [DC_WORD_W-1:0]   merged_c;
    logic [DC_WORD_W-1:0]   word_c;

    assign s_rdy_o  = !m_vld_q || m_rdy_i;
    assign accept_c = s_vld_i && s_rdy_o;
    assign is_eof_c = (s_eof_sb != '0);

    // An SOF byte always restarts assembly at byte 0, dropping any partial word.
    assign eff_idx_c  = s_sof ? '0 : idx_q;
    assign eff_sof_c  = s_sof ? 1'b1 : asm_sof_q;
    assign eff_data_c = s_sof ? '0 : {{DC_BYTE_W{1'b0}}, asm_data_q};
    assign complete_c = accept_c && ((eff_idx_c == 2'd3) || is_eof_c);

    // Place the new byte at its index and zero every byte above it.
    always_comb begin
        merged_c = eff_data_c;
        merged_c[{eff_idx_c, 3'b000} +: DC_BYTE_W] = s_data_i;
        word_c = '0;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (k <= 32'(eff_idx_c)) begin
                word_c[DC_BYTE_W*k +: DC_BYTE_W] = merged_c[DC_BYTE_W*k +: DC_BYTE_W];
            end
        end
    end

    always_comb begin
        asm_data_d = asm_data_q;
        idx_d      = idx_q;
        asm_sof_d  = asm_sof_q;
        m_vld_d    = m_vld_q;
        m_data_d   = m_data_q;
        m_sof_d    = m_sof_q;
        m_eof_sb_d = m_eof_sb_q;
        sof_err_d  = 1'b0;

        if (m_vld_q && m_rdy_i) begin
            m_vld_d = 1'b0;
        end

        if (accept_c) begin
            sof_err_d  = s_sof && (idx_q != '0);
            asm_data_d = merged_c[DC_ASM_W-1:0];
            if (complete_c) begin
                m_vld_d    = 1'b1;
                m_data_d   = word_c;
                m_sof_d    = eff_sof_c;
                m_eof_sb_d = is_eof_c ? eof_code(eff_idx_c) : '0;
                idx_d      = '0;
                asm_sof_d  = 1'b0;
            end else begin
                idx_d     = eff_idx_c + 2'd1;
                asm_sof_d = eff_sof_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data_q <= '0;
            idx_q      <= '0;
            asm_sof_q  <= 1'b0;
            m_vld_q    <= 1'b0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eof_sb_q <= '0;
            sof_err_q  <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            idx_q      <= idx_d;
            asm_sof_q  <= asm_sof_d;
            m_vld_q    <= m_vld_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_eof_sb_q <= m_eof_sb_d;
            sof_err_q  <= sof_err_d;
        end
    end

    assign m_vld_o  = m_vld_q;
    assign m_data_o = m_data_q;
    assign m_sof    = m_sof_q;
    assign m_eof_sb = m_eof_sb_q;
    assign sof_err  = sof_err_q;

endmodule

// File: tb/tb_dc_8to32.sv
// Directed self-checking bench for the dc_8to32 byte-to-word packer.
module tb_dc_8to32;

    logic        clk;
    logic        rst;
    logic        s_vld_i;
    logic [7:0]  s_data_i;
    logic        s_sof;
    logic [2:0]  s_eof_sb;
    logic        s_rdy_o;
    logic        m_vld_o;
    logic [31:0] m_data_o;
    logic        m_sof;
    logic [2:0]  m_eof_sb;
    logic        m_rdy_i;
    logic        sof_err;

    int n_tests;
    int n_fail;

    dc_8to32 dut (
        .clk      (clk),
        .rst      (rst),
        .s_vld_i  (s_vld_i),
        .s_data_i (s_data_i),
        .s_sof    (s_sof),
        .s_eof_sb (s_eof_sb),
        .s_rdy_o  (s_rdy_o),
        .m_vld_o  (m_vld_o),
        .m_data_o (m_data_o),
        .m_sof    (m_sof),
        .m_eof_sb (m_eof_sb),
        .m_rdy_i  (m_rdy_i),
        .sof_err  (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one byte, then step past the next rising edge.
    task automatic drive(input logic [7:0] d, input logic sof, input logic [2:0] eof);
        s_vld_i  = 1'b1;
        s_data_i = d;
        s_sof    = sof;
        s_eof_sb = eof;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_vld_i  = 1'b0;
        s_sof    = 1'b0;
        s_eof_sb = 3'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err, s_rdy_o} !== {1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got vld=%b data=%h sof=%b eof=%0d err=%b rdy=%b, want 0/0/0/0/0/1",
                     m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err, s_rdy_o);
        end
    endtask

    task automatic test_full_word();
        drive(8'h11, 1'b1, 3'd0);
        drive(8'h22, 1'b0, 3'd0);
        drive(8'h33, 1'b0, 3'd0);
        n_tests++;
        if (m_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_early: got vld=%b want 0", m_vld_o);
        end
        drive(8'h44, 1'b0, 3'd1);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'h44332211, 1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL full_word: got vld=%b data=%h sof=%b eof=%0d, want 1/44332211/1/4",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        idle();
        n_tests++;
        if (m_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: got vld=%b want 0", m_vld_o);
        end
    endtask

    task automatic test_six_byte();
        drive(8'hA0, 1'b1, 3'd0);
        drive(8'hA1, 1'b0, 3'd0);
        drive(8'hA2, 1'b0, 3'd0);
        drive(8'hA3, 1'b0, 3'd0);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'hA3A2A1A0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL six_word0: got vld=%b data=%h sof=%b eof=%0d, want 1/a3a2a1a0/1/0",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        drive(8'hA4, 1'b0, 3'd0);
        n_tests++;
        if (m_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL six_mid: got vld=%b want 0", m_vld_o);
        end
        drive(8'hA5, 1'b0, 3'd5);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'h0000A5A4, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL six_word1: got vld=%b data=%h sof=%b eof=%0d, want 1/0000a5a4/0/2",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(8'h5A, 1'b1, 3'd1);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'h0000005A, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL one_byte: got vld=%b data=%h sof=%b eof=%0d, want 1/0000005a/1/1",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        drive(8'h6B, 1'b1, 3'd1);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'h0000006B, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL b2b_drain_load: got vld=%b data=%h sof=%b eof=%0d, want 1/0000006b/1/1",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        m_rdy_i = 1'b0;
        drive(8'h7C, 1'b1, 3'd1);
        n_tests++;
        if ({s_rdy_o, m_vld_o, m_data_o} !== {1'b0, 1'b1, 32'h0000006B}) begin
            n_fail++;
            $display("FAIL b2b_hold: got rdy=%b vld=%b data=%h, want 0/1/0000006b", s_rdy_o, m_vld_o, m_data_o);
        end
        m_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({m_vld_o, m_data_o} !== {1'b1, 32'h0000007C}) begin
            n_fail++;
            $display("FAIL b2b_release: got vld=%b data=%h, want 1/0000007c", m_vld_o, m_data_o);
        end
        idle();
    endtask

    task automatic test_stall();
        int bad;
        m_rdy_i = 1'b0;
        drive(8'hB0, 1'b1, 3'd0);
        drive(8'hB1, 1'b0, 3'd0);
        drive(8'hB2, 1'b0, 3'd0);
        drive(8'hB3, 1'b0, 3'd0);
        s_data_i = 8'hB4;
        s_sof    = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({s_rdy_o, m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b0, 1'b1, 32'hB3B2B1B0, 1'b1, 3'd0}) begin
                bad++;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d unstable cycles, want 0 (rdy=%b data=%h)", bad, s_rdy_o, m_data_o);
        end
        m_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (m_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got vld=%b want 0", m_vld_o);
        end
        drive(8'hB5, 1'b0, 3'd0);
        drive(8'hB6, 1'b0, 3'd0);
        drive(8'hB7, 1'b0, 3'd1);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb} !== {1'b1, 32'hB7B6B5B4, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL stall_resume: got vld=%b data=%h sof=%b eof=%0d, want 1/b7b6b5b4/0/4",
                     m_vld_o, m_data_o, m_sof, m_eof_sb);
        end
        idle();
    endtask

    task automatic test_sof_err();
        drive(8'hC0, 1'b1, 3'd0);
        drive(8'hC1, 1'b0, 3'd0);
        drive(8'hD0, 1'b1, 3'd0);
        n_tests++;
        if ({sof_err, m_vld_o} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sof_err_pulse: got err=%b vld=%b, want 1/0", sof_err, m_vld_o);
        end
        drive(8'hD1, 1'b0, 3'd0);
        n_tests++;
        if (sof_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_err_once: got err=%b want 0", sof_err);
        end
        drive(8'hD2, 1'b0, 3'd0);
        drive(8'hD3, 1'b0, 3'd2);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err} !== {1'b1, 32'hD3D2D1D0, 1'b1, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL sof_restart_word: got vld=%b data=%h sof=%b eof=%0d err=%b, want 1/d3d2d1d0/1/4/0",
                     m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err);
        end
        drive(8'hE0, 1'b1, 3'd0);
        drive(8'hE1, 1'b0, 3'd0);
        drive(8'hF0, 1'b1, 3'd1);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err} !== {1'b1, 32'h000000F0, 1'b1, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL sof_eof_restart: got vld=%b data=%h sof=%b eof=%0d err=%b, want 1/000000f0/1/1/1",
                     m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err);
        end
        idle();
    endtask

    task automatic test_reset_midframe();
        m_rdy_i = 1'b0;
        drive(8'h10, 1'b1, 3'd0);
        drive(8'h20, 1'b0, 3'd0);
        drive(8'h30, 1'b0, 3'd0);
        drive(8'h40, 1'b0, 3'd0);
        s_vld_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err, s_rdy_o} !== {1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_pending: got vld=%b data=%h sof=%b eof=%0d err=%b rdy=%b, want 0/0/0/0/0/1",
                     m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err, s_rdy_o);
        end
        m_rdy_i = 1'b1;
        drive(8'h61, 1'b1, 3'd0);
        drive(8'h62, 1'b0, 3'd0);
        s_vld_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if ({m_vld_o, sof_err, s_rdy_o} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_partial: got vld=%b err=%b rdy=%b, want 0/0/1", m_vld_o, sof_err, s_rdy_o);
        end
        drive(8'h71, 1'b0, 3'd0);
        drive(8'h72, 1'b0, 3'd0);
        drive(8'h73, 1'b0, 3'd0);
        drive(8'h74, 1'b0, 3'd3);
        n_tests++;
        if ({m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err} !== {1'b1, 32'h74737271, 1'b0, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_repack: got vld=%b data=%h sof=%b eof=%0d err=%b, want 1/74737271/0/4/0",
                     m_vld_o, m_data_o, m_sof, m_eof_sb, sof_err);
        end
        idle();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        s_vld_i  = 1'b0;
        s_data_i = 8'h00;
        s_sof    = 1'b0;
        s_eof_sb = 3'd0;
        m_rdy_i  = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_full_word();
        test_six_byte();
        test_back_to_back();
        test_stall();
        test_sof_err();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_8to32.md
# dc_8to32

Byte-to-word width converter for the frame-streaming datapath. Packs an 8-bit valid/ready byte stream with SOF/EOF sideband into 32-bit words, little-endian: the first byte lands in bits [7:0]. Encodes the short final word of a frame in m_eof_sb. Sits upstream of 32-bit consumers such as the FIFO/SPI word path; it is the inverse of the 32-to-8 unpacker.

## Interface
No parameters; widths are fixed: 8 in, 32 out, 3-bit EOF sideband.
- clk  in  1  single clock; one clock domain, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- s_vld_i  in  1  input byte valid
- s_data_i  in  8  input byte
- s_sof  in  1  first byte of frame; qualified by s_vld_i
- s_eof_sb  in  3  nonzero means last byte of frame; qualified by s_vld_i; value otherwise ignored
- s_rdy_o  out  1  byte accepted when s_vld_i && s_rdy_o
- m_vld_o  out  1  output word valid
- m_data_o  out  32  packed word; byte k in bits [8k+:8]
- m_sof  out  1  word contains the frame's first byte
- m_eof_sb  out  3  0 for a non-final word; 1..4 = number of valid bytes in the final word
- m_rdy_i  in  1  downstream ready
- sof_err  out  1  one-cycle pulse: SOF arrived while a partial word was pending

## Operation
- Assembly state: asm_data[23:0], byte index idx[1:0], asm_sof flag.
- Output register: m_data_o, m_sof, m_eof_sb, m_vld_o.
- Accept: s_rdy_o = !m_vld_o || m_rdy_i (combinational). Each accepted byte writes asm_data[8*idx+:8].
- Word completes on an accepted byte when idx==3 or s_eof_sb!=0. On completion:
  - Load the output register with {byte, asm_data} shifted to place the byte at idx.
  - Zero-fill the unused upper bytes.
  - m_sof = asm_sof, or s_sof if idx==0.
  - m_eof_sb = eof ? idx+1 : 0.
  - Clear idx and asm_sof.
- Otherwise idx increments. asm_sof is set if s_sof && idx==0.
- SOF with idx!=0: discard the partial word and pulse sof_err. Treat the byte as byte 0 of a new word with asm_sof=1. If it also carries EOF, emit a 1-byte word with m_sof=1, m_eof_sb=1.
- SOF and EOF on the same byte at idx 0: emit one word with m_sof=1, m_eof_sb=1.
- An output word is consumed on m_vld_o && m_rdy_i. m_vld_o clears unless a new word loads in the same cycle.
- Byte-index wrap: 3 -> 0 on completion only. A non-accepted cycle never advances idx.

## Timing
- Reset: m_vld_o=0, m_data_o=0, m_sof=0, m_eof_sb=0, sof_err=0, idx=0, asm_sof=0, asm_data=0. s_rdy_o=1 after reset, since it follows from m_vld_o=0.
- Latency: the byte completing a word at cycle N gives m_vld_o=1 at N+1.
- Throughput: 1 byte/cycle sustained with m_rdy_i=1. Words emerge every 4 cycles, or earlier on EOF.
- Backpressure: while m_vld_o=1 && m_rdy_i=0, s_rdy_o=0 and all state holds. Output fields stay stable until the handshake completes.
- Simultaneous drain and complete: a word is consumed and a new one loaded in the same cycle; m_vld_o stays 1.
- Reset mid-frame: partial assembly and any pending output word are dropped. No sof_err on reset.
- sof_err is registered and asserted the cycle after the offending byte is accepted.

## Structure
- Shared package dc_pkg: BYTES_PER_WORD=4, DC_BYTE_W=8, DC_WORD_W=32, DC_EOF_SB_W=3, and the EOF_FULL=3'd4 encoding. The 32-to-8 direction uses the same package.
- Single flat module, no sub-modules. The output register is a one-entry holding stage inside the module.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 with SOF on 0x11 and EOF on 0x44, m_rdy_i=1 -> one word 0x44332211 with m_sof=1, m_eof_sb=4, one cycle after 0x44.
- 6-byte frame 0xA0..0xA5 -> 0xA3A2A1A0 (m_sof=1, eof_sb=0), then 0x0000A5A4 (m_sof=0, eof_sb=2).
- 1-byte frame 0x5A with SOF and EOF together -> 0x0000005A, m_sof=1, m_eof_sb=1.
- Stall m_rdy_i=0 for 10 cycles while a word is valid -> s_rdy_o=0, outputs stable, no byte lost. On release, streaming resumes at 1 byte/cycle.
- SOF at idx 2 mid-frame -> sof_err pulses once, partial bytes discarded, and the next word holds the new SOF byte in [7:0] with m_sof=1.
- Assert rst with idx=2 and an output word pending -> next cycle all outputs 0 and s_rdy_o=1. The following 4-byte frame packs from byte 0.
